// File: rtl/ycbcr_to_rgb_stream_if.sv
// Pixel stream bundle for the YCbCr->RGB converter: input pixel handshake
// plus output pixel handshake with frame marker. The design is the slave.
interface ycbcr_to_rgb_stream_if;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_ycc;
  logic        m_valid;
  logic        m_ready;
  logic [23:0] m_rgb;
  logic        m_last;

  modport slave (
    input  s_valid, s_ycc, m_ready,
    output s_ready, m_valid, m_rgb, m_last
  );

  modport master (
    output s_valid, s_ycc, m_ready,
    input  s_ready, m_valid, m_rgb, m_last
  );
endinterface

// File: rtl/ycbcr_to_rgb_stream.sv
// JFIF full-range YCbCr->RGB converter, Q8 coefficients, 3-stage pipeline
// with a global stall and an output frame counter driving m_last.
module ycbcr_to_rgb_stream #(
  parameter int PIXELS_PER_FRAME = 64
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  ycbcr_to_rgb_stream_if.slave  bus
);

  localparam int CW = (PIXELS_PER_FRAME > 1) ? $clog2(PIXELS_PER_FRAME) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(PIXELS_PER_FRAME - 1);

  localparam logic signed [17:0] KR  = 18'sd359;
  localparam logic signed [17:0] KGB = 18'sd88;
  localparam logic signed [17:0] KGR = 18'sd183;
  localparam logic signed [17:0] KB  = 18'sd454;

  function automatic logic [7:0] clamp8(input logic [7:0] y, input logic signed [10:0] off);
    logic signed [11:0] s;
    s = $signed({4'b0000, y}) + 12'(off);
    if (s[11])
      return 8'd0;
    else if (s > 12'sd255)
      return 8'd255;
    else
      return s[7:0];
  endfunction

  logic                en;
  logic signed [8:0]   dcb, dcr;
  logic signed [18:0]  sum_r, sum_g, sum_b;

  logic                v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [7:0]          y1_q, y1_d, y2_q, y2_d;
  logic signed [17:0]  pr_q, pr_d, pgb_q, pgb_d, pgr_q, pgr_d, pb_q, pb_d;
  logic signed [10:0]  sr_q, sr_d, sg_q, sg_d, sb_q, sb_d;
  logic [23:0]         rgb_q, rgb_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  always_comb begin
    en  = ~v3_q | bus.m_ready;
    dcb = $signed({1'b0, bus.s_ycc[15:8]} - 9'd128);
    dcr = $signed({1'b0, bus.s_ycc[23:16]} - 9'd128);

    // Taking bits [18:8] of the rounded sum is the flooring >>> 8.
    sum_r = 19'(pr_q) + 19'sd128;
    sum_g = 19'sd128 - 19'(pgb_q) - 19'(pgr_q);
    sum_b = 19'(pb_q) + 19'sd128;

    v1_d  = v1_q;  y1_d  = y1_q;
    pr_d  = pr_q;  pgb_d = pgb_q; pgr_d = pgr_q; pb_d = pb_q;
    v2_d  = v2_q;  y2_d  = y2_q;
    sr_d  = sr_q;  sg_d  = sg_q;  sb_d  = sb_q;
    v3_d  = v3_q;  rgb_d = rgb_q;

    if (en) begin
      v1_d  = bus.s_valid;
      y1_d  = bus.s_ycc[7:0];
      pr_d  = KR  * 18'(dcr);
      pgb_d = KGB * 18'(dcb);
      pgr_d = KGR * 18'(dcr);
      pb_d  = KB  * 18'(dcb);

      v2_d  = v1_q;
      y2_d  = y1_q;
      sr_d  = sum_r[18:8];
      sg_d  = sum_g[18:8];
      sb_d  = sum_b[18:8];

      v3_d  = v2_q;
      rgb_d = {clamp8(y2_q, sb_q), clamp8(y2_q, sg_q), clamp8(y2_q, sr_q)};
    end

    cnt_d = cnt_q;
    if (v3_q && bus.m_ready)
      cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      rgb_q <= '0;
      cnt_q <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      rgb_q <= rgb_d;
      cnt_q <= cnt_d;
    end
  end

  // Datapath registers need no reset: their contents are qualified by the valids.
  always_ff @(posedge ap_clk) begin
    y1_q  <= y1_d;
    pr_q  <= pr_d;
    pgb_q <= pgb_d;
    pgr_q <= pgr_d;
    pb_q  <= pb_d;
    y2_q  <= y2_d;
    sr_q  <= sr_d;
    sg_q  <= sg_d;
    sb_q  <= sb_d;
  end

  assign bus.s_ready = en & ap_rst_n;
  assign bus.m_valid = v3_q;
  assign bus.m_rgb   = rgb_q;
  assign bus.m_last  = v3_q & (cnt_q == LAST_CNT);

endmodule
